// File: rtl/reg_window_ctrl.sv
// reg_window_ctrl: register-window pointer with spill/fill of the oldest window pair to a memory stack
module reg_window_ctrl #(
    parameter int SP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            call,
    input  logic            ret,
    output logic [1:0]      window,
    output logic            busy,
    output logic            win_err,
    output logic            rf_ovr,
    output logic [1:0]      rf_window,
    output logic [1:0]      rf_ri,
    output logic            rf_reg_write,
    output logic [15:0]     rf_wdata,
    input  logic [15:0]     rf_read_data1,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SP_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack
);
    typedef enum logic [2:0] {IDLE, SPILL0, SPILL1, FILL0, FILL1} state_e;
    state_e          state_q, state_d;
    logic [1:0]      cwp_q, cwp_d, res_q, res_d;
    logic [SP_W:0]   sp_q, sp_d;
    logic            err_q, err_d;
    logic            spill, fill, k;
    logic [SP_W-1:0] sp_lo;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cwp_q   <= '0;
            res_q   <= 2'd1;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            res_q   <= res_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end
    // sp_q never exceeds 2^SP_W, so its top bit alone flags a full stack
    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        res_d   = res_q;
        sp_d    = sp_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (call && ret) begin
                    err_d = 1'b1;
                end else if (call) begin
                    if (res_q != 2'd3) begin
                        cwp_d = cwp_q + 2'd1;
                        res_d = res_q + 2'd1;
                    end else if (!sp_q[SP_W]) begin
                        state_d = SPILL0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ret) begin
                    if (res_q != 2'd1) begin
                        cwp_d = cwp_q - 2'd1;
                        res_d = res_q - 2'd1;
                    end else if (sp_q != '0) begin
                        state_d = FILL0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SPILL0: state_d = mem_ack ? SPILL1 : SPILL0;
            SPILL1: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    cwp_d   = cwp_q + 2'd1;
                    sp_d    = sp_q + (SP_W+1)'(2);
                end
            end
            FILL0: state_d = mem_ack ? FILL1 : FILL0;
            FILL1: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    cwp_d   = cwp_q - 2'd1;
                    sp_d    = sp_q - (SP_W+1)'(2);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign spill        = (state_q == SPILL0) || (state_q == SPILL1);
    assign fill         = (state_q == FILL0) || (state_q == FILL1);
    assign k            = (state_q == SPILL1) || (state_q == FILL1);
    assign sp_lo        = sp_q[SP_W-1:0];
    assign window       = cwp_q;
    assign busy         = state_q != IDLE;
    assign win_err      = err_q;
    assign rf_ovr       = spill || fill;
    assign rf_window    = spill ? cwp_q - 2'd2 : fill ? cwp_q - 2'd1 : 2'd0;
    assign rf_ri        = (spill || fill) ? {1'b0, k} : 2'd0;
    assign rf_reg_write = fill && mem_ack;
    assign rf_wdata     = (fill && mem_ack) ? mem_rdata : 16'd0;
    assign mem_req      = spill || fill;
    assign mem_we       = spill;
    assign mem_addr     = spill ? sp_lo + SP_W'(k) : fill ? sp_lo - SP_W'(2) + SP_W'(k) : '0;
    assign mem_wdata    = spill ? rf_read_data1 : 16'd0;
endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb_reg_window_ctrl: random call/ret traffic against a window/stack reference model,
// with the bench acting as register file and as a variable-latency spill memory
module tb_reg_window_ctrl;
    localparam int SP_W  = 4;
    localparam int PAIRS = 1 << (SP_W - 1);
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, call, ret, busy, win_err, rf_ovr, rf_reg_write, mem_req, mem_we, mem_ack;
    logic [1:0] window, rf_window, rf_ri;
    logic [15:0] rf_wdata, rf_read_data1, mem_wdata, mem_rdata;
    logic [SP_W-1:0] mem_addr;
    logic [15:0] rf [8];
    logic [15:0] mem [1 << SP_W];
    logic [2:0] rf_idx, poke_idx;
    logic [15:0] poke_val;
    logic poke_we = 1'b0;
    int ack_dly = 0;
    int wcnt = 0;
    int checks = 0;
    int errors = 0;
    int m_cwp, m_res;
    logic [31:0] stk [$];
    reg_window_ctrl #(.SP_W(SP_W)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .window(window), .busy(busy),
        .win_err(win_err), .rf_ovr(rf_ovr), .rf_window(rf_window), .rf_ri(rf_ri),
        .rf_reg_write(rf_reg_write), .rf_wdata(rf_wdata), .rf_read_data1(rf_read_data1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );
    assign rf_idx        = {rf_window, 1'b0} + {1'b0, rf_ri};
    assign rf_read_data1 = rf[rf_idx];
    assign mem_ack       = mem_req && (wcnt >= ack_dly);
    assign mem_rdata     = mem[mem_addr];
    always @(posedge clk) begin
        wcnt <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;
        if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
        if (rf_ovr && rf_reg_write) rf[rf_idx] <= rf_wdata;
        else if (poke_we) rf[poke_idx] <= poke_val;
    end
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic poke(input int idx, input logic [15:0] v);
        poke_idx = 3'(idx);
        poke_val = v;
        poke_we  = 1'b1;
        @(posedge clk); #1;
        poke_we = 1'b0;
    endtask
    task automatic model_reset();
        m_cwp = 0;
        m_res = 1;
        stk.delete();
    endtask
    task automatic op(input bit c, input bit r, input int d, input bit inject);
        int kind, base, cyc, k, oc;
        logic [15:0] e0, e1;
        ack_dly = d;
        oc = m_cwp;
        e0 = '0;
        e1 = '0;
        base = 0;
        if (c && r) kind = 4;
        else if (c) kind = (m_res < 3) ? 0 : (stk.size() < PAIRS) ? 2 : 4;
        else kind = (m_res > 1) ? 1 : (stk.size() > 0) ? 3 : 4;
        if (kind == 2) begin
            e0 = rf[(2*oc+4)%8];
            e1 = rf[(2*oc+5)%8];
            base = 2 * stk.size();
        end
        if (kind == 3) begin
            {e0, e1} = stk[$];
            base = 2 * (stk.size() - 1);
        end
        call = c;
        ret = r;
        @(posedge clk); #1;
        call = 1'b0;
        ret = 1'b0;
        check("win_err", win_err, int'(kind == 4));
        if (kind == 0) begin
            m_cwp = (m_cwp + 1) % 4;
            m_res++;
        end
        if (kind == 1) begin
            m_cwp = (m_cwp + 3) % 4;
            m_res--;
        end
        if (kind < 2 || kind == 4) begin
            check("window", window, m_cwp);
            check("busy_plain", busy, 0);
            check("mem_req_plain", mem_req, 0);
            if (kind == 4) begin
                @(posedge clk); #1;
                check("err_pulse", win_err, 0);
            end
        end else begin
            check("busy_rise", busy, 1);
            cyc = 0;
            k = 0;
            while (busy && cyc < 40) begin
                check("hold_win", window, oc);
                check("err_busy", win_err, 0);
                check("rf_ovr", rf_ovr, 1);
                check("rf_window", rf_window, kind == 2 ? (oc + 2) % 4 : (oc + 3) % 4);
                check("rf_ri", rf_ri, k);
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, int'(kind == 2));
                check("mem_addr", mem_addr, base + k);
                if (mem_ack) k++;
                if (inject && cyc == 1) call = 1'b1;
                @(posedge clk); #1;
                call = 1'b0;
                cyc++;
            end
            check("busy_len", cyc, 2 * (d + 1));
            check("words", k, 2);
            if (kind == 2) begin
                m_cwp = (oc + 1) % 4;
                stk.push_back({e0, e1});
                check("spill_w0", mem[base], e0);
                check("spill_w1", mem[base+1], e1);
            end else begin
                m_cwp = (oc + 3) % 4;
                void'(stk.pop_back());
                check("fill_r0", rf[(2*m_cwp)%8], e0);
                check("fill_r1", rf[(2*m_cwp+1)%8], e1);
            end
            check("window_end", window, m_cwp);
            check("err_end", win_err, 0);
            check("mem_req_end", mem_req, 0);
        end
    endtask
    initial begin
        bit seen;
        int g;
        rst = 1'b1;
        call = 1'b0;
        ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_window", window, 0);
        check("rst_busy", busy, 0);
        check("rst_err", win_err, 0);
        check("rst_ovr", rf_ovr, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;
        model_reset();
        op(1, 0, 0, 0);
        op(1, 0, 0, 0);
        poke(0, 16'h0011);
        poke(1, 16'h0022);
        op(1, 0, 0, 0);
        check("plan_mem0", mem[0], 16'h0011);
        check("plan_mem1", mem[1], 16'h0022);
        op(0, 1, 0, 0);
        op(0, 1, 0, 0);
        poke(0, 16'hdead);
        poke(1, 16'hbeef);
        op(0, 1, 0, 0);
        check("plan_r0", rf[0], 16'h0011);
        check("plan_r1", rf[1], 16'h0022);
        check("plan_win0", window, 0);
        op(0, 1, 0, 0);
        op(1, 1, 0, 0);
        op(1, 0, 0, 0);
        op(1, 0, 0, 0);
        op(1, 0, 3, 1);
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) poke($urandom_range(0, 7), 16'($urandom));
            g = $urandom_range(0, 3);
            op(sel < 5 || sel == 9, sel >= 5, g, g > 0 && $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 14; i++) op(1, 0, $urandom_range(0, 2), 0);
        for (int i = 0; i < 16; i++) op(0, 1, $urandom_range(0, 2), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        op(1, 0, 0, 0);
        op(1, 0, 0, 0);
        ack_dly = 3;
        call = 1'b1;
        @(posedge clk); #1;
        call = 1'b0;
        seen = 1'b0;
        g = 0;
        while (!seen && g < 20) begin
            if (mem_ack) seen = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        check("reach_spill1", seen, 1);
        check("spill1_addr", mem_addr, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_win", window, 0);
        check("rst_mid_busy", busy, 0);
        model_reset();
        op(0, 1, 0, 0);
        op(1, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_window_ctrl.md
# reg_window_ctrl

Window controller for the 8×16-bit windowed register file: it owns the current window pointer, advances it on call and retreats it on return. When a call would overwrite the oldest live window it spills two registers to a memory stack; when a return needs registers that were spilled it fills them back. It sits between the CPU control unit (call/ret, stall) and the register file. It takes over the register-file port through an override mux while spilling or filling.

## Interface
- SP_W, 4: spill-stack word-address width; capacity 2^SP_W words = 2^(SP_W-1) spilled pairs
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- call  in  1  one-cycle pulse: enter new window
- ret  in  1  one-cycle pulse: return to previous window
- window  out  2  current window pointer (CWP) to register file
- busy  out  1  spill/fill in progress; CPU must stall
- win_err  out  1  one-cycle pulse: illegal call/ret, request ignored
- rf_ovr  out  1  1 = register-file port driven by rf_* below instead of CPU
- rf_window  out  2  window index during override
- rf_ri  out  2  Ri during override; read_data1 returns spill data
- rf_reg_write  out  1  write strobe during fill
- rf_wdata  out  16  fill write data
- rf_read_data1  in  16  register-file read_data1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (spill), 0 = read (fill)
- mem_addr  out  SP_W  stack word address
- mem_wdata  out  16  spill data
- mem_rdata  in  16  fill data, valid with mem_ack
- mem_ack  in  1  one-cycle completion; may arrive in the same cycle as mem_req

## Operation
- Mapping (fixed by the register file): window w, index Ri → physical R[(2w+Ri) mod 8].
  - Window w's Ri=2,3 alias window w+1's Ri=0,1. Call is therefore CWP+1 and ret is CWP−1, both mod 4.
- State:
  - CWP (2 b)
  - resident count RES (1..3), the number of windows live in the file: max 3, since 3 windows × 4 regs minus 2 overlaps = 8
  - stack pointer SP (SP_W+1 b, always even)
  - FSM {IDLE, SPILL0, SPILL1, FILL0, FILL1}
- IDLE, call:
  - RES<3: CWP+1, RES+1.
  - RES==3 and SP<2^SP_W: go to SPILL0. The oldest window is CWP−2, whose Ri=0,1 equal physical R[2·CWP+4 mod 8].
  - RES==3 and SP==2^SP_W: stack full; win_err, no change.
- IDLE, ret:
  - RES>1: CWP−1, RES−1.
  - RES==1 and SP>0: go to FILL0.
  - RES==1 and SP==0: underflow; win_err, no change.
- IDLE, call and ret together: win_err, no change.
- SPILL0/SPILL1 (k=0/1):
  - Outputs: rf_ovr=1, rf_window=CWP−2, rf_ri=k, mem_req=1, mem_we=1, mem_addr=SP+k, mem_wdata=rf_read_data1.
  - On mem_ack, SPILL0→SPILL1.
  - On mem_ack, SPILL1→IDLE with CWP+1, SP+2; RES stays 3.
- FILL0/FILL1 (k=0/1):
  - Outputs: rf_ovr=1, rf_window=CWP−1, rf_ri=k, mem_req=1, mem_we=0, mem_addr=SP−2+k.
  - On mem_ack: rf_reg_write=1 and rf_wdata=mem_rdata in that same cycle.
  - On mem_ack, FILL0→FILL1.
  - On mem_ack, FILL1→IDLE with CWP−1, SP−2; RES stays 1.
- busy = (state≠IDLE). call/ret arriving while busy are ignored (no win_err).
- All rf_*/mem_* outputs are combinational from the state and are 0 in IDLE.
- Window arithmetic is mod 4. SP never wraps: the full/empty checks above prevent it.

## Timing
- Reset values:
  - window=0, RES=1, SP=0, state=IDLE
  - busy=0, win_err=0, rf_ovr=0, rf_reg_write=0, mem_req=0, mem_we=0
  - mem_addr, mem_wdata and rf_wdata = 0
- rst has priority over all inputs. Reset mid-spill/fill drops mem_req on the next cycle and discards the partial transfer; SP is not updated.
- Plain call/ret: window changes at the edge that samples the pulse (latency 1); busy stays 0.
- Spill/fill: busy rises at the edge sampling call/ret. Each word costs ≥1 cycle, ending in the mem_ack cycle.
  - With zero-wait ack: busy lasts 2 cycles and window updates at the edge ending FILL1/SPILL1.
- win_err is registered: high for exactly the cycle after the offending request.

## Test plan
- Reset, then call, call: window 0→1→2 one cycle after each pulse; busy=0; mem_req never asserted.
- With R0=0x0011, R1=0x0022, CWP=2, RES=3, pulse call (mem_ack immediate):
  - writes 0x0011 to addr 0, then 0x0022 to addr 1
  - busy is high for 2 cycles, then window=3 and SP=2
- Continuing, ret, ret: window 3→2→1 (RES 3→2→1, no mem). Corrupt R0/R1, then ret:
  - reads addr 0, 1; rf writes window 0, Ri 0/1 restore R0=0x0011 and R1=0x0022
  - window=0, SP=0
- After reset, ret: win_err pulses one cycle, window stays 0. call+ret in the same cycle: win_err, window unchanged.
- mem_ack delayed 3 cycles per word during a spill:
  - mem_req/mem_addr stay stable until ack; busy lasts 8 cycles
  - a call pulse during busy is ignored
- rst asserted in SPILL1: next cycle mem_req=0, window=0, busy=0, SP=0.
